crc16_stream: RTL and testbench

CRC16_STREAM -- requirements
Module: crc16_stream

---
 rtl/crc16_pkg.sv | 13 +
 rtl/crc16_step.sv | 27 ++
 rtl/crc16_stream.sv | 98 +++++++++
 tb/tb_crc16_stream.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc16_pkg.sv
// rtl/crc16_pkg.sv - shared constants and FSM state type for the CRC16 stream block
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY_CCITT = 16'h1021;
  localparam logic [15:0] CRC16_INIT_ONES  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } crc16_state_e;

endpackage

// File: rtl/crc16_step.sv
// rtl/crc16_step.sv - combinational DATA_W-bit CRC16 advance, MSB first, non-reflected
module crc16_step
  import crc16_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter logic [15:0] POLY   = CRC16_POLY_CCITT
) (
  input  logic [15:0]       crc,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       next
);

  logic [15:0] acc;
  logic        fb;

  // One shift/XOR stage per data bit, highest bit folded in first.
  always_comb begin
    acc = crc;
    fb  = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = acc[15] ^ data[i];
      acc = {acc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end
    next = acc;
  end

endmodule

// File: rtl/crc16_stream.sv
// rtl/crc16_stream.sv - framed CRC16 over a valid/ready beat stream; CRC16_RESIDUE_CHECK_EN adds crc_ok
module crc16_stream
  import crc16_pkg::*;
#(
  parameter int          DATA_W = 8,
  parameter logic [15:0] POLY   = CRC16_POLY_CCITT,
  parameter logic [15:0] INIT   = CRC16_INIT_ONES,
  parameter logic [15:0] XOROUT = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       crc_out,
  output logic              crc_ok,
  output logic              frame_err
);

  crc16_state_e state_q, state_d;
  logic [15:0]  crc_q, crc_d;
  logic         err_q, err_d;
  logic [15:0]  step_seed;
  logic [15:0]  step_next;
  logic         accept;

  assign accept    = in_valid && in_ready;
  // A start-of-frame beat always folds into a fresh INIT, whatever the state.
  assign step_seed = in_sop ? INIT : crc_q;

  crc16_step #(
    .DATA_W(DATA_W),
    .POLY  (POLY)
  ) u_step (
    .crc (step_seed),
    .data(in_data),
    .next(step_next)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    err_d     = 1'b0;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_sop) begin
            crc_d   = step_next;
            state_d = in_eop ? ST_DONE : ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          crc_d = step_next;
          err_d = in_sop;
          if (in_eop) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign crc_out   = crc_q ^ XOROUT;
  assign frame_err = err_q;

`ifdef CRC16_RESIDUE_CHECK_EN
  assign crc_ok = out_valid && (crc_q == 16'h0000);
`else
  assign crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_crc16_stream.sv
// tb/tb_crc16_stream.sv - randomized and directed checks of crc16_stream against a frame-level model
module tb_crc16_stream;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [15:0] POLY   = 16'h1021;
  localparam logic [15:0] INIT   = 16'hFFFF;
  localparam logic [15:0] XOROUT = 16'h0000;
`ifdef CRC16_RESIDUE_CHECK_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;

  logic        in_valid8 = 1'b0, in_sop8 = 1'b0, in_eop8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  in_data8 = '0;
  logic        in_ready8, out_valid8, crc_ok8, frame_err8;
  logic [15:0] crc_out8;

  logic        in_valid32 = 1'b0, in_sop32 = 1'b0, in_eop32 = 1'b0, out_ready32 = 1'b1;
  logic [31:0] in_data32 = '0;
  logic        in_ready32, out_valid32, crc_ok32, frame_err32;
  logic [15:0] crc_out32;

  int n_checks = 0;
  int n_fail   = 0;
  int err_seen = 0;
  bit rnd_en   = 1'b0;

  bit      m_done = 1'b0;
  bit      m_busy = 1'b0;
  bit      m_err  = 1'b0;
  byte_q_t m_bytes;

  crc16_stream #(.DATA_W(8)) dut8 (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_sop(in_sop8), .in_eop(in_eop8), .out_valid(out_valid8),
    .out_ready(out_ready8), .crc_out(crc_out8), .crc_ok(crc_ok8), .frame_err(frame_err8)
  );

  crc16_stream #(.DATA_W(32)) dut32 (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_sop(in_sop32), .in_eop(in_eop32), .out_valid(out_valid32),
    .out_ready(out_ready32), .crc_out(crc_out32), .crc_ok(crc_ok32), .frame_err(frame_err32)
  );

  initial forever #5 clk = ~clk;

  // Polynomial long division of the message, one bit at a time, MSB of each byte first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 7; k >= 0; k--) r = (r[15] ^ b[k]) ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_msg(input byte_q_t q);
    logic [15:0] r;
    r = INIT;
    foreach (q[i]) r = crc_byte(r, q[i]);
    return r;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference for the 8-bit instance: which bytes the register currently covers.
  initial forever begin
    @(posedge clk or negedge reset_L);
    if (!reset_L) begin
      m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_bytes.delete();
    end else begin
      m_err = 1'b0;
      if (m_done) begin
        if (out_ready8) m_done = 1'b0;
      end else if (in_valid8) begin
        if (in_sop8) begin
          m_err   = m_busy;
          m_bytes = {in_data8};
          m_busy  = !in_eop8;
          m_done  = in_eop8;
        end else if (m_busy) begin
          m_bytes.push_back(in_data8);
          if (in_eop8) begin m_busy = 1'b0; m_done = 1'b1; end
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  initial forever begin
    logic [15:0] raw;
    @(negedge clk);
    if (reset_L) begin
      raw = crc_msg(m_bytes);
      check1("out_valid", out_valid8, m_done);
      check1("in_ready", in_ready8, !m_done);
      check1("frame_err", frame_err8, m_err);
      check16("crc_out", crc_out8, raw ^ XOROUT);
      check1("crc_ok", crc_ok8, RES_EN && m_done && (raw == 16'h0000));
      if (frame_err8) err_seen++;
    end
  end

  task automatic beat8(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = d; in_sop8 = s; in_eop8 = e;
    if (rnd_en) out_ready8 = ($urandom_range(0, 2) != 0);
    while (!in_ready8 && n < 200) begin
      @(negedge clk);
      n++;
      if (rnd_en) out_ready8 = ($urandom_range(0, 1) != 0);
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL beat8_timeout: in_ready stuck 0, required 1");
    end
    @(posedge clk);
  endtask

  task automatic idle8(input int k);
    repeat (k) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      in_data8  = 8'($urandom);
      in_sop8   = 1'($urandom);
      in_eop8   = 1'($urandom);
    end
  endtask

  task automatic send_frame8(input byte_q_t q, input bit with_eop);
    for (int i = 0; i < q.size(); i++) begin
      if (rnd_en && i > 0 && $urandom_range(0, 3) == 0) idle8(1);
      beat8(q[i], i == 0, with_eop && (i == q.size() - 1));
    end
  endtask

  task automatic beat32(input logic [31:0] d, input logic s, input logic e);
    int n = 0;
    @(negedge clk);
    in_valid32 = 1'b1; in_data32 = d; in_sop32 = s; in_eop32 = e;
    while (!in_ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL beat32_timeout: in_ready stuck 0, required 1");
    end
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t msg, bad, q, w8;
    int e0;
    logic [31:0] w[$];
    for (int i = 0; i < 9; i++) msg.push_back(8'(8'h31 + i));

    check16("model_check_string", crc_msg(msg), 16'h29B1);
    q.delete();
    check16("model_empty", crc_msg(q), 16'hFFFF);

    repeat (3) @(negedge clk);
    check1("rst_out_valid", out_valid8, 1'b0);
    check1("rst_in_ready", in_ready8, 1'b1);
    check16("rst_crc_out", crc_out8, INIT ^ XOROUT);
    check1("rst_frame_err", frame_err8, 1'b0);
    check1("rst_crc_ok", crc_ok8, 1'b0);
    reset_L = 1'b1;

    send_frame8(msg, 1'b1);
    #1;
    check1("ascii_latency", out_valid8, 1'b1);
    check16("ascii_crc", crc_out8, 16'h29B1);
    idle8(2);

    q = msg; q.push_back(8'h29); q.push_back(8'hB1);
    send_frame8(q, 1'b1);
    #1;
    check16("residue_crc", crc_out8, 16'h0000);
    check1("residue_ok", crc_ok8, RES_EN);
    idle8(2);
    bad = q; bad[0] = 8'h30;
    send_frame8(bad, 1'b1);
    #1;
    check1("residue_bad_ok", crc_ok8, 1'b0);
    idle8(2);

    out_ready8 = 1'b0;
    send_frame8(msg, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      check1("stall_in_ready", in_ready8, 1'b0);
      check16("stall_crc", crc_out8, 16'h29B1);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    check1("stall_release_valid", out_valid8, 1'b0);
    check1("stall_release_ready", in_ready8, 1'b1);
    idle8(2);

    e0 = err_seen;
    q = {8'h31, 8'h32, 8'h33};
    send_frame8(q, 1'b0);
    send_frame8(msg, 1'b1);
    #1;
    check16("restart_crc", crc_out8, 16'h29B1);
    idle8(3);
    check16("restart_err_count", 16'(err_seen - e0), 16'd1);

    e0 = err_seen;
    beat8(8'h55, 1'b0, 1'b0);
    #1;
    check1("stray_err", frame_err8, 1'b1);
    idle8(3);
    check1("stray_no_valid", out_valid8, 1'b0);
    check16("stray_err_count", 16'(err_seen - e0), 16'd1);

    q = {8'h31, 8'h32, 8'h33, 8'h34};
    send_frame8(q, 1'b0);
    #2;
    reset_L = 1'b0;
    in_valid8 = 1'b0;
    #1;
    check1("reset_mid_valid", out_valid8, 1'b0);
    check16("reset_mid_crc", crc_out8, INIT ^ XOROUT);
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    send_frame8(msg, 1'b1);
    #1;
    check16("post_reset_crc", crc_out8, 16'h29B1);
    idle8(2);

    beat32(32'h31323334, 1'b1, 1'b0);
    beat32(32'h35363738, 1'b0, 1'b1);
    #1;
    w8.delete();
    for (int i = 0; i < 8; i++) w8.push_back(8'(8'h31 + i));
    check1("w32_valid", out_valid32, 1'b1);
    check16("w32_crc8bytes", crc_out32, crc_msg(w8));
    check16("w32_plus_odd_byte", crc_byte(crc_msg(w8), 8'h39), 16'h29B1);
    @(negedge clk);
    in_valid32 = 1'b0;
    for (int f = 0; f < 4; f++) begin
      int nw;
      nw = $urandom_range(1, 4);
      w.delete(); w8.delete();
      for (int i = 0; i < nw; i++) begin
        w.push_back($urandom);
        for (int b = 3; b >= 0; b--) w8.push_back(w[i][8*b +: 8]);
      end
      for (int i = 0; i < nw; i++) beat32(w[i], i == 0, i == nw - 1);
      #1;
      check16("w32_random_crc", crc_out32, crc_msg(w8) ^ XOROUT);
      @(negedge clk);
      in_valid32 = 1'b0;
    end

    rnd_en = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 8);
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      if (kind == 0) begin
        beat8(8'($urandom), 1'b0, 1'($urandom));
      end else if (kind == 1) begin
        send_frame8(q, 1'b0);
      end else begin
        send_frame8(q, 1'b1);
      end
      idle8($urandom_range(0, 2));
    end
    rnd_en = 1'b0;
    out_ready8 = 1'b1;
    idle8(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
